wb_stage_seq: RTL and testbench

- Registered write-back stage for the pipelined RISC core; generalised, sequential successor to the combinational write-data select.
- Latches the MEM/WB bundle and selects one of eight write-back sources, zero-extending 1-bit flags to DATA_W.
- Waits on slow data-memory/cache returns, supports flush and halt, and drives the register-file write port plus a retire counter.

---
 rtl/wb_stage_seq.sv | 200 ++++++++++++++++++++
 tb/tb_wb_stage_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_seq.sv
// Registered write-back stage: selects one of eight sources, waits on slow data memory, retires entries.
// Optional macro WB_MEM_TIMEOUT_EN bounds the memory wait and raises a sticky mem_err on expiry.
module wb_stage_seq #(
  parameter int DATA_W      = 16,
  parameter int RADDR_W     = 3,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic [2:0]         wb_sel,
  input  logic               wr_en_in,
  input  logic [RADDR_W-1:0] wr_reg_in,
  input  logic               halt_in,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic [DATA_W-1:0]  dmem_out,
  input  logic [DATA_W-1:0]  rs_val,
  input  logic [DATA_W-1:0]  pc_2,
  input  logic               dmem_done,
  input  logic               zero,
  input  logic               lt,
  input  logic               lte,
  input  logic               cout,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               retire_pulse,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic               halted,
  output logic               mem_err
);

  typedef enum logic {RUN, WAIT_MEM} state_t;

  state_t             state_q, state_d;
  logic               rf_we_q, rf_we_d;
  logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
  logic               retire_pulse_q, retire_pulse_d;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
  logic               halted_q, halted_d;
  logic               pend_we_q, pend_we_d;
  logic [RADDR_W-1:0] pend_reg_q, pend_reg_d;
  logic               pend_halt_q, pend_halt_d;

  logic               accept;
  logic [DATA_W-1:0]  sel_data;
  logic               do_retire;
  logic               ret_we;
  logic [RADDR_W-1:0] ret_reg;
  logic [DATA_W-1:0]  ret_data;
  logic               ret_halt;

`ifdef WB_MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             mem_err_q, mem_err_d;
  assign mem_err = mem_err_q;
`else
  assign mem_err = 1'b0;
`endif

  assign in_ready = (state_q == RUN) && !halted_q;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    case (wb_sel)
      3'd0:    sel_data = alu_out;
      3'd1:    sel_data = dmem_out;
      3'd2:    sel_data = pc_2;
      3'd3:    sel_data = rs_val;
      3'd4:    sel_data = {{(DATA_W-1){1'b0}}, zero};
      3'd5:    sel_data = {{(DATA_W-1){1'b0}}, lt};
      3'd6:    sel_data = {{(DATA_W-1){1'b0}}, lte};
      default: sel_data = {{(DATA_W-1){1'b0}}, cout};
    endcase
  end

  always_comb begin
    state_d        = state_q;
    rf_we_d        = 1'b0;
    retire_pulse_d = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    retire_cnt_d   = retire_cnt_q;
    halted_d       = halted_q;
    pend_we_d      = pend_we_q;
    pend_reg_d     = pend_reg_q;
    pend_halt_d    = pend_halt_q;
    do_retire      = 1'b0;
    ret_we         = 1'b0;
    ret_reg        = pend_reg_q;
    ret_data       = dmem_out;
    ret_halt       = 1'b0;
`ifdef WB_MEM_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    mem_err_d      = mem_err_q;
`endif

    case (state_q)
      RUN: begin
        if (accept) begin
          if (wb_sel != 3'd1 || dmem_done) begin
            do_retire = 1'b1;
            ret_we    = wr_en_in;
            ret_reg   = wr_reg_in;
            ret_data  = sel_data;
            ret_halt  = halt_in;
          end else begin
            pend_we_d   = wr_en_in;
            pend_reg_d  = wr_reg_in;
            pend_halt_d = halt_in;
            state_d     = WAIT_MEM;
`ifdef WB_MEM_TIMEOUT_EN
            tmo_cnt_d   = '0;
`endif
          end
        end
      end
      WAIT_MEM: begin
        // flush has priority over a memory return arriving in the same cycle
        if (flush) begin
          state_d = RUN;
        end else if (dmem_done) begin
          do_retire = 1'b1;
          ret_we    = pend_we_q;
          ret_halt  = pend_halt_q;
          state_d   = RUN;
        end
`ifdef WB_MEM_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(MEM_TIMEOUT - 1)) begin
          do_retire = 1'b1;
          ret_we    = pend_we_q;
          ret_data  = '0;
          ret_halt  = pend_halt_q;
          mem_err_d = 1'b1;
          state_d   = RUN;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      default: state_d = RUN;
    endcase

    if (do_retire) begin
      rf_we_d        = ret_we;
      rf_waddr_d     = ret_reg;
      rf_wdata_d     = ret_data;
      retire_pulse_d = 1'b1;
      retire_cnt_d   = retire_cnt_q + CNT_W'(1);
      if (ret_halt) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      retire_pulse_q <= 1'b0;
      retire_cnt_q   <= '0;
      halted_q       <= 1'b0;
      pend_we_q      <= 1'b0;
      pend_reg_q     <= '0;
      pend_halt_q    <= 1'b0;
`ifdef WB_MEM_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      mem_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      retire_pulse_q <= retire_pulse_d;
      retire_cnt_q   <= retire_cnt_d;
      halted_q       <= halted_d;
      pend_we_q      <= pend_we_d;
      pend_reg_q     <= pend_reg_d;
      pend_halt_q    <= pend_halt_d;
`ifdef WB_MEM_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
      mem_err_q      <= mem_err_d;
`endif
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign retire_pulse = retire_pulse_q;
  assign retire_cnt   = retire_cnt_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_wb_stage_seq.sv
// Scoreboard bench for wb_stage_seq: a transaction-level model predicts each retirement,
// a negedge monitor compares whatever the stage presents against the queued predictions.
module tb_wb_stage_seq;

  localparam int DATA_W      = 16;
  localparam int RADDR_W     = 3;
  localparam int CNT_W       = 8;
  localparam int MEM_TIMEOUT = 4;

  logic               clk, rst;
  logic               in_valid, in_ready, flush;
  logic [2:0]         wb_sel;
  logic               wr_en_in, halt_in;
  logic [RADDR_W-1:0] wr_reg_in;
  logic [DATA_W-1:0]  alu_out, dmem_out, rs_val, pc_2;
  logic               dmem_done, zero, lt, lte, cout;
  logic               rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic               retire_pulse;
  logic [CNT_W-1:0]   retire_cnt;
  logic               halted, mem_err;

  wb_stage_seq #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .wb_sel(wb_sel), .wr_en_in(wr_en_in), .wr_reg_in(wr_reg_in), .halt_in(halt_in),
    .alu_out(alu_out), .dmem_out(dmem_out), .rs_val(rs_val), .pc_2(pc_2),
    .dmem_done(dmem_done), .zero(zero), .lt(lt), .lte(lte), .cout(cout),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire_pulse(retire_pulse),
    .retire_cnt(retire_cnt), .halted(halted), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic               we;
    logic [RADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  wdata;
    logic [CNT_W-1:0]   cnt;
    logic               hlt;
    logic               err;
  } obs_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit rst_at_edge = 1'b0;

  obs_t exp_q[$];
  int   due_q[$];

  // reference model: one optional pending memory entry plus sticky status
  bit                 m_pending, m_pwe, m_phalt, m_halted, m_err;
  logic [RADDR_W-1:0] m_preg;
  int                 m_waits, m_cnt;

  always @(posedge clk) begin
    rst_at_edge = rst;
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.we = rf_we; o.waddr = rf_waddr; o.wdata = rf_wdata;
    o.cnt = retire_cnt; o.hlt = halted; o.err = mem_err;
    return o;
  endfunction

  // monitor: owns the "last retired" view used to check hold behaviour
  obs_t last;
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_at_edge) begin
        last = '0;
        chk("reset_outputs", 64'(dut_obs()), 64'(last));
        chk("reset_retire_pulse", 64'(retire_pulse), 64'd0);
      end else if (retire_pulse === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_retire", 64'(retire_pulse), 64'd0);
        end else begin
          obs_t e;
          int d;
          e = exp_q.pop_front();
          d = due_q.pop_front();
          chk("retire_cycle", 64'(cyc), 64'(d));
          chk("retire_data", 64'(dut_obs()), 64'(e));
          last = e;
          last.we = 1'b0;
        end
      end else begin
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
          chk("missing_retire", 64'(retire_pulse), 64'd1);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
        chk("idle_hold", 64'(dut_obs()), 64'(last));
      end
    end
  end

  task automatic push_retire(input bit we, input logic [RADDR_W-1:0] r,
                             input logic [DATA_W-1:0] data, input bit hlt);
    obs_t e;
    m_cnt = (m_cnt + 1) % (2 ** CNT_W);
    if (hlt) m_halted = 1'b1;
    e.we = we; e.waddr = r; e.wdata = data;
    e.cnt = CNT_W'(m_cnt); e.hlt = m_halted; e.err = m_err;
    exp_q.push_back(e);
    due_q.push_back(cyc + 1);
  endtask

  // apply the currently driven inputs for one cycle, predicting the outcome
  task automatic step();
    logic [DATA_W-1:0] src[8];
    bit ready;
    src[0] = alu_out; src[1] = dmem_out; src[2] = pc_2; src[3] = rs_val;
    src[4] = DATA_W'(zero); src[5] = DATA_W'(lt); src[6] = DATA_W'(lte); src[7] = DATA_W'(cout);
    ready = !m_pending && !m_halted;
    chk("in_ready", 64'(in_ready), 64'(ready));
    if (rst) begin
      m_pending = 0; m_halted = 0; m_err = 0; m_cnt = 0; m_waits = 0;
    end else if (m_pending) begin
      if (flush) m_pending = 0;
      else if (dmem_done) begin
        m_pending = 0;
        push_retire(m_pwe, m_preg, dmem_out, m_phalt);
      end else begin
        m_waits++;
`ifdef WB_MEM_TIMEOUT_EN
        if (m_waits == MEM_TIMEOUT) begin
          m_pending = 0;
          m_err = 1;
          push_retire(m_pwe, m_preg, '0, m_phalt);
        end
`endif
      end
    end else if (in_valid && ready && !flush) begin
      if (wb_sel != 3'd1 || dmem_done) push_retire(wr_en_in, wr_reg_in, src[wb_sel], halt_in);
      else begin
        m_pending = 1; m_pwe = wr_en_in; m_preg = wr_reg_in; m_phalt = halt_in; m_waits = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 0; in_valid = 0; flush = 0; wb_sel = 0; wr_en_in = 0; wr_reg_in = 0; halt_in = 0;
    alu_out = 0; dmem_out = 0; rs_val = 0; pc_2 = 0; dmem_done = 0;
    zero = 0; lt = 0; lte = 0; cout = 0;
  endtask

  task automatic entry(input logic [2:0] sel, input logic [RADDR_W-1:0] r, input bit we, input bit hlt);
    in_valid = 1; wb_sel = sel; wr_reg_in = r; wr_en_in = we; halt_in = hlt;
  endtask

  initial begin
    m_pending = 0; m_halted = 0; m_err = 0; m_cnt = 0; m_waits = 0; m_pwe = 0; m_phalt = 0; m_preg = '0;
    set_idle();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;

    // single ALU write, then an idle cycle
    entry(3'd0, 3'd5, 1, 0); alu_out = 16'h1234; step();
    set_idle(); step();

    // flag sources back to back
    entry(3'd5, 3'd2, 1, 0); lt = 1; alu_out = 16'hFFFF; step();
    set_idle(); entry(3'd7, 3'd3, 1, 0); cout = 0; lt = 1; step();
    set_idle(); step();

    // slow memory return after three waiting cycles; stray in_valid must be ignored
    entry(3'd1, 3'd4, 1, 0); dmem_out = 16'h1111; step();
    repeat (3) begin set_idle(); entry(3'd0, 3'd7, 1, 0); alu_out = 16'hDEAD; step(); end
    set_idle(); dmem_done = 1; dmem_out = 16'hBEEF; step();
    set_idle(); step();

    // flush beats dmem_done while waiting
    entry(3'd1, 3'd6, 1, 0); step();
    set_idle(); flush = 1; dmem_done = 1; dmem_out = 16'hCAFE; step();
    set_idle(); step();

    // reset in the middle of a memory wait
    entry(3'd1, 3'd1, 1, 0); step();
    set_idle(); rst = 1; dmem_done = 1; dmem_out = 16'h5A5A; step();
    set_idle(); step();

`ifdef WB_MEM_TIMEOUT_EN
    // memory never returns: timeout retires zero and flags mem_err
    entry(3'd1, 3'd6, 1, 0); step();
    repeat (MEM_TIMEOUT) begin set_idle(); dmem_out = 16'h7777; step(); end
    set_idle(); step();
`endif

    // halt entry without a write, later entries ignored, reset clears
    entry(3'd0, 3'd2, 0, 1); alu_out = 16'h4242; step();
    repeat (3) begin set_idle(); entry(3'd0, 3'd3, 1, 0); alu_out = 16'h9999; step(); end
    set_idle(); rst = 1; step();
    set_idle(); step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_idle();
      rst       = (m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0;
      in_valid  = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 9) == 0;
      wb_sel    = 3'($urandom_range(0, 7));
      wr_en_in  = $urandom_range(0, 3) != 0;
      wr_reg_in = RADDR_W'($urandom);
      halt_in   = $urandom_range(0, 39) == 0;
      alu_out   = DATA_W'($urandom);
      dmem_out  = DATA_W'($urandom);
      rs_val    = DATA_W'($urandom);
      pc_2      = DATA_W'($urandom);
      dmem_done = $urandom_range(0, 2) == 0;
      {zero, lt, lte, cout} = 4'($urandom);
      step();
    end

    set_idle();
    repeat (3) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
